mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 41 ++++
 rtl/mem_arbiter_if.sv | 64 ++++++
 rtl/mem_arbiter_wr_chan.sv | 107 ++++++++++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and constants for the mem_arbiter slice: read/write FSM
//   state encodings, read-owner tag, AXI response code and the helper that
//   sizes the data-read streak counter.
//   No ports (package).

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        OWN_IM = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int DEFAULT_MAX_DM_STREAK = 4;

    // The streak counter has to hold the value MAX_DM_STREAK itself
    // (saturation point), hence clog2(max + 1).
    function automatic int streak_width(input int max_streak);
        if (max_streak < 1) begin
            return 1;
        end
        return $clog2(max_streak + 1);
    endfunction

    localparam int DEFAULT_STREAK_W = streak_width(DEFAULT_MAX_DM_STREAK);

endpackage

// File: rtl/mem_arbiter_if.sv
// axi5_lite_if
//   AXI5-Lite bundle used on all three sides of mem_arbiter.
//   Handshake rule on every channel: a transfer happens in a cycle where
//   both valid and ready are 1 at the rising clock edge; the payload is
//   sampled in that same cycle.
//   Modports:
//     M - the bus master side (drives AW/W/AR payload + valids, bready, rready)
//     S - the bus slave side  (drives awready, wready, arready, B and R)

interface axi5_lite_if #(
    parameter int XLEN = 32
);
    // Write address
    logic              awvalid;
    logic              awready;
    logic [XLEN-1:0]   awaddr;
    logic [2:0]        awprot;
    // Write data
    logic              wvalid;
    logic              wready;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] wstrb;
    // Write response
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    // Read address
    logic              arvalid;
    logic              arready;
    logic [XLEN-1:0]   araddr;
    logic [2:0]        arprot;
    // Read data
    logic              rvalid;
    logic              rready;
    logic [XLEN-1:0]   rdata;
    logic [1:0]        rresp;

    modport M (
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport S (
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );

endinterface

// File: rtl/mem_arbiter_wr_chan.sv
// mem_arbiter_wr_chan
//   Data-master write path: accepts one AW+W pair at a time from dm_s,
//   replays it to mem_m with independent AW/W completion, then forwards the
//   B response back. One write outstanding at most.
//   Ports:
//     clk, rst     - clock, synchronous active-high reset
//     dm_s         - data master (AW/W/B channels used here)
//     mem_m        - memory slave (AW/W/B channels used here)
//     rd_holds_dm  - read side owns dm this cycle or is granting it now;
//                    blocks write accept to keep dm read/write ordered
//     wr_state     - current write FSM state (debug/observability)

module mem_arbiter_wr_chan
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst,
    axi5_lite_if.S    dm_s,
    axi5_lite_if.M    mem_m,
    input  logic      rd_holds_dm,
    output wr_state_e wr_state
);

    logic [XLEN-1:0]   aw_addr_q;
    logic [2:0]        aw_prot_q;
    logic [XLEN-1:0]   w_data_q;
    logic [XLEN/8-1:0] w_strb_q;
    logic              aw_pend_q;
    logic              w_pend_q;

    logic accept;
    logic aw_done;
    logic w_done;
    logic b_hs;

    // Both halves of the write must be offered together; a lone AW or W
    // is left waiting upstream.
    assign accept = (wr_state == W_IDLE) && !rst && dm_s.awvalid
                    && dm_s.wvalid && !rd_holds_dm;

    // A channel counts as done if it already completed earlier or
    // completes in this cycle.
    assign aw_done = !aw_pend_q || mem_m.awready;
    assign w_done  = !w_pend_q  || mem_m.wready;
    assign b_hs    = (wr_state == W_RESP) && mem_m.bvalid && dm_s.bready;

    assign dm_s.awready = accept;
    assign dm_s.wready  = accept;
    assign dm_s.bvalid  = (wr_state == W_RESP) && mem_m.bvalid;
    assign dm_s.bresp   = mem_m.bresp;

    assign mem_m.awvalid = aw_pend_q;
    assign mem_m.awaddr  = aw_addr_q;
    assign mem_m.awprot  = aw_prot_q;
    assign mem_m.wvalid  = w_pend_q;
    assign mem_m.wdata   = w_data_q;
    assign mem_m.wstrb   = w_strb_q;
    assign mem_m.bready  = (wr_state == W_RESP) && dm_s.bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state  <= W_IDLE;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (accept) begin
                        aw_addr_q <= dm_s.awaddr;
                        aw_prot_q <= dm_s.awprot;
                        w_data_q  <= dm_s.wdata;
                        w_strb_q  <= dm_s.wstrb;
                        aw_pend_q <= 1'b1;
                        w_pend_q  <= 1'b1;
                        wr_state  <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (aw_pend_q && mem_m.awready) begin
                        aw_pend_q <= 1'b0;
                    end
                    if (w_pend_q && mem_m.wready) begin
                        w_pend_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        wr_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        wr_state <= W_IDLE;
                    end
                end
                default: begin
                    wr_state <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one AXI5-Lite memory port between the instruction-fetch master
//   (read only) and the data master (read/write). Reads are arbitrated with
//   data-first priority and a streak limit so fetch cannot starve; each
//   read response is steered back to its owner. Data writes pass through
//   mem_arbiter_wr_chan with one write outstanding.
//   Ports:
//     clk, rst      - clock, synchronous active-high reset
//     im_s          - instruction-fetch master (AR/R only, write side tied off)
//     dm_s          - data master (all five channels)
//     mem_m         - shared memory slave (all five channels)
//     dbg_rd_state  - read FSM state
//     dbg_wr_state  - write FSM state
//     dbg_streak    - consecutive contended data-read grants

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int XLEN          = 32,
    parameter  int MAX_DM_STREAK = DEFAULT_MAX_DM_STREAK,
    localparam int STREAK_W      = streak_width(MAX_DM_STREAK)
) (
    input  logic                clk,
    input  logic                rst,
    axi5_lite_if.S              im_s,
    axi5_lite_if.S              dm_s,
    axi5_lite_if.M              mem_m,
    output rd_state_e           dbg_rd_state,
    output wr_state_e           dbg_wr_state,
    output logic [STREAK_W-1:0] dbg_streak
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    rd_state_e           rd_state;
    wr_state_e           wr_state;
    owner_e              owner_q;
    logic [XLEN-1:0]     ar_addr_q;
    logic [2:0]          ar_prot_q;
    logic                ar_valid_q;
    logic [STREAK_W-1:0] streak_q;

    logic im_cand;
    logic dm_cand;
    logic rd_idle;
    logic grant_im;
    logic grant_dm;
    logic in_rdata;
    logic owner_rready;
    logic r_hs;
    logic rd_holds_dm;

    // ------------------------------------------------------------------
    // Read arbitration
    // ------------------------------------------------------------------
    // A dm read may only start while no dm write is in flight; this keeps
    // the data master's reads and writes in program order.
    assign rd_idle  = (rd_state == R_IDLE) && !rst;
    assign im_cand  = im_s.arvalid;
    assign dm_cand  = dm_s.arvalid && (wr_state == W_IDLE);
    assign grant_dm = rd_idle && dm_cand && (!im_cand || (streak_q != STREAK_MAX));
    assign grant_im = rd_idle && im_cand && !grant_dm;

    assign im_s.arready = grant_im;
    assign dm_s.arready = grant_dm;

    assign mem_m.arvalid = ar_valid_q;
    assign mem_m.araddr  = ar_addr_q;
    assign mem_m.arprot  = ar_prot_q;

    // ------------------------------------------------------------------
    // Read response steering
    // ------------------------------------------------------------------
    assign in_rdata     = (rd_state == R_DATA);
    assign owner_rready = (owner_q == OWN_IM) ? im_s.rready : dm_s.rready;
    assign r_hs         = in_rdata && mem_m.rvalid && owner_rready;

    assign mem_m.rready = in_rdata && owner_rready;

    assign im_s.rvalid = in_rdata && (owner_q == OWN_IM) && mem_m.rvalid;
    assign im_s.rdata  = mem_m.rdata;
    assign im_s.rresp  = mem_m.rresp;
    assign dm_s.rvalid = in_rdata && (owner_q == OWN_DM) && mem_m.rvalid;
    assign dm_s.rdata  = mem_m.rdata;
    assign dm_s.rresp  = mem_m.rresp;

    // Fetch master never writes.
    assign im_s.awready = 1'b0;
    assign im_s.wready  = 1'b0;
    assign im_s.bvalid  = 1'b0;
    assign im_s.bresp   = RESP_OKAY;

    logic unused_im_wr;
    assign unused_im_wr = &{1'b0, im_s.awvalid, im_s.awaddr, im_s.awprot,
                            im_s.wvalid, im_s.wdata, im_s.wstrb, im_s.bready};

    // ------------------------------------------------------------------
    // Read FSM + streak counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state   <= R_IDLE;
            owner_q    <= OWN_IM;
            ar_addr_q  <= '0;
            ar_prot_q  <= '0;
            ar_valid_q <= 1'b0;
            streak_q   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (grant_im) begin
                        owner_q    <= OWN_IM;
                        ar_addr_q  <= im_s.araddr;
                        ar_prot_q  <= im_s.arprot;
                        ar_valid_q <= 1'b1;
                        rd_state   <= R_ADDR;
                    end else if (grant_dm) begin
                        owner_q    <= OWN_DM;
                        ar_addr_q  <= dm_s.araddr;
                        ar_prot_q  <= dm_s.arprot;
                        ar_valid_q <= 1'b1;
                        rd_state   <= R_ADDR;
                    end
                    // The streak only measures dm wins that actually made
                    // fetch wait; any gap in fetch demand resets it.
                    if (grant_im || !im_s.arvalid) begin
                        streak_q <= '0;
                    end else if (grant_dm && (streak_q != STREAK_MAX)) begin
                        streak_q <= streak_q + 1'b1;
                    end
                end
                R_ADDR: begin
                    if (mem_m.arready) begin
                        ar_valid_q <= 1'b0;
                        rd_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        rd_state <= R_IDLE;
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    // Same-cycle dm AR and AW/W: the read grant wins and the write waits
    // until the read's response has been taken.
    assign rd_holds_dm = grant_dm || ((rd_state != R_IDLE) && (owner_q == OWN_DM));

    mem_arbiter_wr_chan #(
        .XLEN (XLEN)
    ) u_wr_chan (
        .clk         (clk),
        .rst         (rst),
        .dm_s        (dm_s),
        .mem_m       (mem_m),
        .rd_holds_dm (rd_holds_dm),
        .wr_state    (wr_state)
    );

    assign dbg_rd_state = rd_state;
    assign dbg_wr_state = wr_state;
    assign dbg_streak   = streak_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: single fetch read, contention with the
//   streak limit, write with late W, read/write interlock, R backpressure
//   and reset in the middle of traffic.

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic      clk;
    logic      rst;
    rd_state_e dbg_rd_state;
    wr_state_e dbg_wr_state;
    logic [2:0] dbg_streak;

    int n_checks = 0;
    int n_errors = 0;

    // {owner(1=dm), streak-at-grant[2:0]}
    logic [3:0] exp_q[$];
    int         n_grants;
    logic [3:0] got;

    axi5_lite_if #(.XLEN(32)) im_if ();
    axi5_lite_if #(.XLEN(32)) dm_if ();
    axi5_lite_if #(.XLEN(32)) mem_if ();

    mem_arbiter #(
        .XLEN          (32),
        .MAX_DM_STREAK (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .im_s         (im_if),
        .dm_s         (dm_if),
        .mem_m        (mem_if),
        .dbg_rd_state (dbg_rd_state),
        .dbg_wr_state (dbg_wr_state),
        .dbg_streak   (dbg_streak)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic init_bus();
        im_if.awvalid = 0; im_if.awaddr = 0; im_if.awprot = 0;
        im_if.wvalid = 0; im_if.wdata = 0; im_if.wstrb = 0; im_if.bready = 0;
        im_if.arvalid = 0; im_if.araddr = 0; im_if.arprot = 0; im_if.rready = 0;
        dm_if.awvalid = 0; dm_if.awaddr = 0; dm_if.awprot = 0;
        dm_if.wvalid = 0; dm_if.wdata = 0; dm_if.wstrb = 0; dm_if.bready = 0;
        dm_if.arvalid = 0; dm_if.araddr = 0; dm_if.arprot = 0; dm_if.rready = 0;
        mem_if.awready = 0; mem_if.wready = 0; mem_if.bvalid = 0; mem_if.bresp = 0;
        mem_if.arready = 0; mem_if.rvalid = 0; mem_if.rdata = 0; mem_if.rresp = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        init_bus();
        tick();
        tick();

        // Reset state; arready stays low even with a request pending.
        im_if.arvalid = 1;
        settle();
        chk("rst_rd_state", dbg_rd_state, R_IDLE);
        chk("rst_wr_state", dbg_wr_state, W_IDLE);
        chk("rst_streak", dbg_streak, 0);
        chk("rst_im_arready", im_if.arready, 0);
        chk("rst_mem_arvalid", mem_if.arvalid, 0);
        chk("rst_mem_awvalid", mem_if.awvalid, 0);
        chk("rst_mem_araddr", mem_if.araddr, 0);

        // ---- single im read ----
        tick();
        rst = 0;
        im_if.arvalid = 1; im_if.araddr = 32'h100;
        mem_if.arready = 1;
        settle();
        chk("t1_im_arready", im_if.arready, 1);
        chk("t1_dm_arready", dm_if.arready, 0);
        tick();
        im_if.arvalid = 0;
        settle();
        chk("t1_mem_arvalid", mem_if.arvalid, 1);
        chk("t1_mem_araddr", mem_if.araddr, 32'h100);
        chk("t1_rd_state", dbg_rd_state, R_ADDR);
        tick();
        mem_if.rvalid = 1; mem_if.rdata = 32'hDEADBEEF; im_if.rready = 1;
        settle();
        chk("t1_im_rvalid", im_if.rvalid, 1);
        chk("t1_im_rdata", im_if.rdata, 32'hDEADBEEF);
        chk("t1_dm_rvalid", dm_if.rvalid, 0);
        chk("t1_mem_rready", mem_if.rready, 1);
        tick();
        mem_if.rvalid = 0;
        settle();
        chk("t1_back_idle", dbg_rd_state, R_IDLE);
        chk("t1_im_rvalid_low", im_if.rvalid, 0);

        // ---- contention: dm,dm,dm,dm,im,dm ----
        tick();
        exp_q.push_back({1'b1, 3'd0});
        exp_q.push_back({1'b1, 3'd1});
        exp_q.push_back({1'b1, 3'd2});
        exp_q.push_back({1'b1, 3'd3});
        exp_q.push_back({1'b0, 3'd4});
        exp_q.push_back({1'b1, 3'd0});
        n_grants = 0;
        im_if.arvalid = 1; im_if.araddr = 32'h1000;
        dm_if.arvalid = 1; dm_if.araddr = 32'h2000;
        im_if.rready = 1; dm_if.rready = 1;
        mem_if.arready = 1; mem_if.rvalid = 1; mem_if.rdata = 32'h0;
        for (int c = 0; c < 18; c++) begin
            settle();
            if (im_if.arready || dm_if.arready) begin
                n_grants++;
                got = {dm_if.arready, dbg_streak};
                if (exp_q.size() > 0) begin
                    chk("cont_grant_and_streak", got, exp_q.pop_front());
                end
            end
            tick();
        end
        im_if.arvalid = 0; dm_if.arvalid = 0; mem_if.rvalid = 0;
        chk("cont_grant_count", n_grants, 6);
        settle();
        chk("cont_idle", dbg_rd_state, R_IDLE);

        // ---- data write with delayed W ----
        tick();
        mem_if.awready = 1; mem_if.wready = 0;
        dm_if.awvalid = 1; dm_if.awaddr = 32'h200;
        dm_if.wvalid = 1; dm_if.wdata = 32'h12345678; dm_if.wstrb = 4'b1111;
        dm_if.bready = 1;
        settle();
        chk("w_dm_awready", dm_if.awready, 1);
        chk("w_dm_wready", dm_if.wready, 1);
        tick();
        dm_if.awvalid = 0; dm_if.wvalid = 0;
        settle();
        chk("w_mem_awvalid_c1", mem_if.awvalid, 1);
        chk("w_mem_wvalid_c1", mem_if.wvalid, 1);
        chk("w_mem_awaddr", mem_if.awaddr, 32'h200);
        chk("w_mem_wdata", mem_if.wdata, 32'h12345678);
        chk("w_mem_wstrb", mem_if.wstrb, 4'b1111);
        tick();
        settle();
        chk("w_mem_awvalid_c2", mem_if.awvalid, 0);
        chk("w_mem_wvalid_c2", mem_if.wvalid, 1);
        tick();
        settle();
        chk("w_mem_wvalid_c3", mem_if.wvalid, 1);
        chk("w_dm_bvalid_c3", dm_if.bvalid, 0);
        tick();
        mem_if.wready = 1;
        settle();
        chk("w_mem_wvalid_c4", mem_if.wvalid, 1);
        tick();
        mem_if.wready = 0;
        settle();
        chk("w_mem_wvalid_c5", mem_if.wvalid, 0);
        chk("w_state_resp", dbg_wr_state, W_RESP);
        chk("w_dm_bvalid_c5", dm_if.bvalid, 0);
        tick();
        mem_if.bvalid = 1; mem_if.bresp = RESP_OKAY;
        settle();
        chk("w_dm_bvalid_c6", dm_if.bvalid, 1);
        chk("w_mem_bready", mem_if.bready, 1);
        chk("w_dm_bresp", dm_if.bresp, RESP_OKAY);
        tick();
        mem_if.bvalid = 0;
        settle();
        chk("w_back_idle", dbg_wr_state, W_IDLE);

        // ---- read/write interlock ----
        tick();
        mem_if.awready = 1; mem_if.wready = 1;
        dm_if.arvalid = 1; dm_if.araddr = 32'h300;
        dm_if.awvalid = 1; dm_if.awaddr = 32'h400;
        dm_if.wvalid = 1; dm_if.wdata = 32'hCAFEF00D; dm_if.wstrb = 4'b0011;
        settle();
        chk("il_dm_arready", dm_if.arready, 1);
        chk("il_dm_awready_blocked", dm_if.awready, 0);
        tick();
        dm_if.arvalid = 0;
        settle();
        chk("il_awready_radd", dm_if.awready, 0);
        tick();
        mem_if.rvalid = 1; mem_if.rdata = 32'h55; dm_if.rready = 1;
        settle();
        chk("il_dm_rdata", dm_if.rdata, 32'h55);
        chk("il_awready_rdata", dm_if.awready, 0);
        tick();
        mem_if.rvalid = 0;
        settle();
        chk("il_awready_after_r", dm_if.awready, 1);
        tick();
        dm_if.awvalid = 0; dm_if.wvalid = 0;
        settle();
        chk("il_mem_awaddr", mem_if.awaddr, 32'h400);
        tick();
        im_if.arvalid = 1; im_if.araddr = 32'h500;
        dm_if.arvalid = 1; dm_if.araddr = 32'h510;
        settle();
        chk("il_wr_in_resp", dbg_wr_state, W_RESP);
        chk("il_im_arready_during_w", im_if.arready, 1);
        chk("il_dm_ar_blocked_by_w", dm_if.arready, 0);
        tick();
        im_if.arvalid = 0;
        mem_if.bvalid = 1;
        settle();
        chk("il_dm_bvalid", dm_if.bvalid, 1);
        chk("il_dm_arready_busy", dm_if.arready, 0);
        tick();
        mem_if.bvalid = 0;
        mem_if.rvalid = 1; mem_if.rdata = 32'h77; im_if.rready = 1;
        settle();
        chk("il_im_rdata", im_if.rdata, 32'h77);
        chk("il_im_rvalid", im_if.rvalid, 1);
        chk("il_dm_rvalid", dm_if.rvalid, 0);
        tick();
        mem_if.rvalid = 0;
        settle();
        chk("il_dm_ar_after", dm_if.arready, 1);
        tick();
        dm_if.arvalid = 0;
        settle();
        chk("il_mem_araddr_dm", mem_if.araddr, 32'h510);

        // ---- backpressure on the dm read ----
        tick();
        mem_if.rvalid = 1; mem_if.rdata = 32'h99; dm_if.rready = 0;
        im_if.arvalid = 1; im_if.araddr = 32'h600;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_mem_rready", mem_if.rready, 0);
            chk("bp_im_arready", im_if.arready, 0);
            chk("bp_dm_rvalid", dm_if.rvalid, 1);
            tick();
        end
        dm_if.rready = 1;
        settle();
        chk("bp_mem_rready_rel", mem_if.rready, 1);
        chk("bp_dm_rdata", dm_if.rdata, 32'h99);
        tick();
        mem_if.rvalid = 0;
        settle();
        chk("bp_im_arready_after", im_if.arready, 1);

        // ---- reset in R_DATA + W_REQ ----
        tick();
        im_if.arvalid = 0;
        mem_if.awready = 0; mem_if.wready = 0;
        dm_if.awvalid = 1; dm_if.awaddr = 32'h700;
        dm_if.wvalid = 1; dm_if.wdata = 32'h1; dm_if.wstrb = 4'b0001;
        settle();
        chk("rm_dm_awready", dm_if.awready, 1);
        tick();
        dm_if.awvalid = 0; dm_if.wvalid = 0;
        mem_if.rvalid = 1; im_if.rready = 0;
        settle();
        chk("rm_pre_rd_state", dbg_rd_state, R_DATA);
        chk("rm_pre_wr_state", dbg_wr_state, W_REQ);
        chk("rm_pre_mem_awvalid", mem_if.awvalid, 1);
        rst = 1;
        im_if.arvalid = 1;
        tick();
        settle();
        chk("rm_rd_state", dbg_rd_state, R_IDLE);
        chk("rm_wr_state", dbg_wr_state, W_IDLE);
        chk("rm_streak", dbg_streak, 0);
        chk("rm_mem_arvalid", mem_if.arvalid, 0);
        chk("rm_mem_awvalid", mem_if.awvalid, 0);
        chk("rm_mem_wvalid", mem_if.wvalid, 0);
        chk("rm_im_rvalid", im_if.rvalid, 0);
        chk("rm_im_arready", im_if.arready, 0);
        chk("rm_mem_rready", mem_if.rready, 0);
        chk("rm_mem_wdata", mem_if.wdata, 0);
        tick();
        rst = 0;
        mem_if.rvalid = 0; mem_if.arready = 1;
        im_if.araddr = 32'h800; im_if.rready = 1;
        settle();
        chk("rm_new_im_arready", im_if.arready, 1);
        tick();
        im_if.arvalid = 0;
        settle();
        chk("rm_new_mem_araddr", mem_if.araddr, 32'h800);
        tick();
        mem_if.rvalid = 1; mem_if.rdata = 32'hA5A5A5A5;
        settle();
        chk("rm_new_im_rvalid", im_if.rvalid, 1);
        chk("rm_new_im_rdata", im_if.rdata, 32'hA5A5A5A5);
        tick();
        mem_if.rvalid = 0;
        settle();
        chk("rm_new_idle", dbg_rd_state, R_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
